flag_unit: RTL and testbench
============================

# flag_unit

Status-flag producer for the processor datapath. Computes N, Z, C, V from the execute-stage operands and ALU operation, then holds them in an architectural flag register. Output `Flags` feeds the condition-check logic, which returns `CondEx` to gate the next flag write. Also provides a single-entry saved-flags register for exception entry and return.

## Interface
- `WIDTH`, 32: datapath width of `SrcA` and `SrcB`.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `Valid`  input  1  the instruction in execute is real (not a bubble).
- `Stall`  input  1  hold all state this cycle.
- `ALUControl`  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `SrcA`  input  WIDTH  operand A.
- `SrcB`  input  WIDTH  operand B.
- `FlagW`  input  2  bit1 enables the N and Z update; bit0 enables the C and V update.
- `CondEx`  input  1  condition passed for the current instruction.
- `Save`  input  1  copy `Flags` into `SavedFlags`.
- `Restore`  input  1  load `Flags` from `SavedFlags`.
- `Flags`  output  4  committed flags, packed {N,Z,C,V} (bit3 = N).
- `SavedFlags`  output  4  saved copy, same packing.
- `FlagUpdated`  output  1  registered pulse: `Flags` changed value on the previous edge.

## Operation
- Internal result, computed combinationally:
  - ADD: `{cout,res} = {0,SrcA} + {0,SrcB}`, (WIDTH+1) bits wide.
  - SUB: `{cout,res} = {0,SrcA} + {0,~SrcB} + 1`.
  - AND: `SrcA & SrcB`.
  - ORR: `SrcA | SrcB`.
- Flag values:
  - N = `res[WIDTH-1]`.
  - Z = (res == 0).
  - C = `cout`. For SUB, C = 1 means no borrow.
  - V (ADD) = (A[msb] == B[msb]) & (res[msb] != A[msb]).
  - V (SUB) = (A[msb] != B[msb]) & (res[msb] != A[msb]).
- Write qualifier: `we = Valid & CondEx & ~Stall`.
  - NZ group updates when `we & FlagW[1]`.
  - CV group updates when `we & FlagW[0] & ~ALUControl[1]`. Logic ops never change C or V, even if `FlagW[0]` = 1.
- Save: `SavedFlags` <= `Flags` when `Save & ~Stall`. It captures the pre-edge value, including when a flag write lands on the same edge.
- Restore: `Flags` <= `SavedFlags` when `Restore & ~Stall`.
- Priority on `Flags`: reset > Stall (hold) > Restore > computed update > hold.
- `Save` and `Restore` in the same cycle: the two registers swap.
- `FlagUpdated` <= (next `Flags` != current `Flags`). Writing identical values gives 0.

## Timing
- Reset: on the first edge with `reset` = 0, `Flags` = 0000, `SavedFlags` = 0000, `FlagUpdated` = 0. Any write in progress is discarded. Reset in the middle of a Save/Restore sequence leaves both registers at 0.
- Update latency is 1 cycle. Inputs sampled at edge k appear on `Flags` after edge k. The checker sees the new flags for the instruction sampled at edge k+1.
- There is no combinational path from any input to `Flags`, `SavedFlags` or `FlagUpdated`. All outputs are registers.
- `CondEx` may depend combinationally on `Flags`. That is legal: `Flags` is registered, so no loop forms.
- Stall freezes all three registers; `FlagUpdated` is forced to 0 on that edge.
- Wrap-around: `res` is taken mod 2^WIDTH. The carry is taken only from bit WIDTH.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001 with FlagW = 11, CondEx = 1, Valid = 1 -> `Flags` = 1001 after one edge; `FlagUpdated` = 1.
- SUB 5 - 5 -> `Flags` = 0110. Then SUB 3 - 5 -> `Flags` = 1000. Then ADD 0xFFFFFFFF + 1 -> `Flags` = 0110.
- Set `Flags` = 0011, then AND 0xF0 & 0x0F with FlagW = 11 -> `Flags` = 0111 (C and V kept); `FlagUpdated` = 1.
- Gating: with a valid update otherwise present, each of CondEx = 0, Valid = 0, Stall = 1 and FlagW = 00 -> `Flags` unchanged and `FlagUpdated` = 0.
- Save/Restore:
  - `Flags` = 1001; Save together with SUB 5 - 5 -> `SavedFlags` = 1001, `Flags` = 0110.
  - Restore -> `Flags` = 1001.
  - From `Flags` = 1001, `SavedFlags` = 0110, Save & Restore together -> the values swap.
- Reset asserted during an update cycle -> `Flags` = 0000, `SavedFlags` = 0000, `FlagUpdated` = 0 on that edge.

Source files
------------

// File: rtl/flag_unit_if.sv
// Execute-stage flag interface: operands, qualifiers and save/restore controls in,
// committed and saved flags out.
interface flag_unit_if #(
    parameter int WIDTH = 32
);
    logic             Valid;
    logic             Stall;
    logic [1:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [1:0]       FlagW;
    logic             CondEx;
    logic             Save;
    logic             Restore;
    logic [3:0]       Flags;
    logic [3:0]       SavedFlags;
    logic             FlagUpdated;

    modport master (
        output Valid, Stall, ALUControl, SrcA, SrcB, FlagW, CondEx, Save, Restore,
        input  Flags, SavedFlags, FlagUpdated
    );

    modport slave (
        input  Valid, Stall, ALUControl, SrcA, SrcB, FlagW, CondEx, Save, Restore,
        output Flags, SavedFlags, FlagUpdated
    );
endinterface

// File: rtl/flag_unit.sv
// NZCV flag producer with an architectural flag register and a single-entry
// saved-flags register for exception entry/return. All outputs are registered.
module flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    flag_unit_if.slave  bus
);
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             n_flag, z_flag, c_flag, v_flag;
    logic             we;

    logic [3:0] flags_q, flags_d;
    logic [3:0] saved_q, saved_d;
    logic       upd_q, upd_d;

    // SUB reuses the adder: A + ~B + 1, so SrcB's msb is inverted for the V test too.
    assign src_a    = bus.SrcA;
    assign src_b_op = bus.ALUControl[0] ? ~bus.SrcB : bus.SrcB;
    assign sum      = {1'b0, src_a} + {1'b0, src_b_op} + {{WIDTH{1'b0}}, bus.ALUControl[0]};

    always_comb begin
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        case (bus.ALUControl)
            2'b10: begin
                res  = bus.SrcA & bus.SrcB;
                cout = 1'b0;
            end
            2'b11: begin
                res  = bus.SrcA | bus.SrcB;
                cout = 1'b0;
            end
            default: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
        endcase
    end

    assign n_flag = res[WIDTH-1];
    assign z_flag = (res == '0);
    assign c_flag = cout;
    assign v_flag = (src_a[WIDTH-1] == src_b_op[WIDTH-1]) && (res[WIDTH-1] != src_a[WIDTH-1]);

    assign we = bus.Valid & bus.CondEx & ~bus.Stall;

    always_comb begin
        flags_d = flags_q;
        saved_d = saved_q;
        upd_d   = 1'b0;
        if (!bus.Stall) begin
            if (bus.Restore) begin
                flags_d = saved_q;
            end else begin
                if (we && bus.FlagW[1]) begin
                    flags_d[3:2] = {n_flag, z_flag};
                end
                // Logic ops leave C and V untouched regardless of FlagW[0].
                if (we && bus.FlagW[0] && !bus.ALUControl[1]) begin
                    flags_d[1:0] = {c_flag, v_flag};
                end
            end
            if (bus.Save) begin
                saved_d = flags_q;
            end
            upd_d = (flags_d != flags_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= 4'b0000;
            saved_q <= 4'b0000;
            upd_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            saved_q <= saved_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.Flags       = flags_q;
    assign bus.SavedFlags  = saved_q;
    assign bus.FlagUpdated = upd_q;
endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed cases from the test plan followed by
// randomized traffic checked against an arithmetic reference model.
module tb_flag_unit;
    logic clk;
    logic reset;
    int   checks_q;
    int   failures_q;

    logic [3:0] m_flags;
    logic [3:0] m_saved;
    logic       m_upd;

    flag_unit_if #(.WIDTH(32)) bus ();

    flag_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            failures_q++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference NZCV from signed/unsigned integer arithmetic.
    function automatic logic [3:0] ref_nzcv(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua, ub, us;
        longint          sa, sb, ss;
        logic [31:0]     r;
        logic            c, v;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0;
        case (op)
            2'd0: begin
                us = ua + ub;
                r  = us[31:0];
                c  = (us >= 64'h1_0000_0000);
                ss = sa + sb;
                v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'd1: begin
                us = ua - ub;
                r  = us[31:0];
                c  = (ua >= ub);
                ss = sa - sb;
                v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r[31], (r == 32'd0), c, v};
    endfunction

    task automatic apply(input string tag, input logic rst_n, input logic vld, input logic stl,
                         input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fw, input logic cond, input logic sv, input logic rs);
        logic [3:0] nzcv, nxt;
        reset          = rst_n;
        bus.Valid      = vld;
        bus.Stall      = stl;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.FlagW      = fw;
        bus.CondEx     = cond;
        bus.Save       = sv;
        bus.Restore    = rs;
        nzcv = ref_nzcv(op, a, b);
        @(posedge clk);
        if (!rst_n) begin
            m_flags = 4'b0; m_saved = 4'b0; m_upd = 1'b0;
        end else if (stl) begin
            m_upd = 1'b0;
        end else begin
            nxt = m_flags;
            if (rs) nxt = m_saved;
            else if (vld && cond) begin
                if (fw[1]) nxt[3:2] = nzcv[3:2];
                if (fw[0] && op < 2'd2) nxt[1:0] = nzcv[1:0];
            end
            if (sv) m_saved = m_flags;
            m_upd   = (nxt != m_flags);
            m_flags = nxt;
        end
        #1;
        $display("txn %-10s rst=%b v=%b st=%b op=%0d a=%h b=%h fw=%b ce=%b sv=%b rs=%b -> flags=%b saved=%b upd=%b",
                 tag, rst_n, vld, stl, op, a, b, fw, cond, sv, rs,
                 bus.Flags, bus.SavedFlags, bus.FlagUpdated);
        check({tag, ".flags"}, {28'd0, bus.Flags}, {28'd0, m_flags});
        check({tag, ".saved"}, {28'd0, bus.SavedFlags}, {28'd0, m_saved});
        check({tag, ".upd"}, {31'd0, bus.FlagUpdated}, {31'd0, m_upd});
    endtask

    initial begin
        checks_q = 0;
        failures_q = 0;
        m_flags = 4'b0; m_saved = 4'b0; m_upd = 1'b0;

        apply("reset", 1'b0, 0, 0, 2'd0, 32'd0, 32'd0, 2'b00, 0, 0, 0);
        check("reset_const", {28'd0, bus.Flags}, 32'h0);

        apply("add_ovf", 1'b1, 1, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 1, 0, 0);
        check("add_ovf_c", {28'd0, bus.Flags}, 32'b1001);
        check("add_ovf_u", {31'd0, bus.FlagUpdated}, 32'd1);
        apply("sub_eq", 1'b1, 1, 0, 2'd1, 32'd5, 32'd5, 2'b11, 1, 0, 0);
        check("sub_eq_c", {28'd0, bus.Flags}, 32'b0110);
        apply("sub_neg", 1'b1, 1, 0, 2'd1, 32'd3, 32'd5, 2'b11, 1, 0, 0);
        check("sub_neg_c", {28'd0, bus.Flags}, 32'b1000);
        apply("add_wrap", 1'b1, 1, 0, 2'd0, 32'hFFFF_FFFF, 32'h1, 2'b11, 1, 0, 0);
        check("add_wrap_c", {28'd0, bus.Flags}, 32'b0110);

        apply("sub_0011", 1'b1, 1, 0, 2'd1, 32'h8000_0000, 32'h1, 2'b11, 1, 0, 0);
        check("sub_0011_c", {28'd0, bus.Flags}, 32'b0011);
        apply("and_keep", 1'b1, 1, 0, 2'd2, 32'hF0, 32'h0F, 2'b11, 1, 0, 0);
        check("and_keep_c", {28'd0, bus.Flags}, 32'b0111);
        check("and_keep_u", {31'd0, bus.FlagUpdated}, 32'd1);

        apply("g_cond", 1'b1, 1, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 0, 0, 0);
        apply("g_valid", 1'b1, 0, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 1, 0, 0);
        apply("g_stall", 1'b1, 1, 1, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 1, 0, 0);
        apply("g_fw00", 1'b1, 1, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b00, 1, 0, 0);
        check("gate_c", {28'd0, bus.Flags}, 32'b0111);
        check("gate_u", {31'd0, bus.FlagUpdated}, 32'd0);

        apply("set1001", 1'b1, 1, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 1, 0, 0);
        apply("save_sub", 1'b1, 1, 0, 2'd1, 32'd5, 32'd5, 2'b11, 1, 1, 0);
        check("save_sub_s", {28'd0, bus.SavedFlags}, 32'b1001);
        check("save_sub_f", {28'd0, bus.Flags}, 32'b0110);
        apply("restore", 1'b1, 0, 0, 2'd0, 32'd0, 32'd0, 2'b00, 0, 0, 1);
        check("restore_f", {28'd0, bus.Flags}, 32'b1001);
        apply("set0110", 1'b1, 1, 0, 2'd1, 32'd5, 32'd5, 2'b11, 1, 0, 0);
        apply("save0110", 1'b1, 0, 0, 2'd0, 32'd0, 32'd0, 2'b00, 0, 1, 0);
        apply("set1001b", 1'b1, 1, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 1, 0, 0);
        apply("swap", 1'b1, 0, 0, 2'd0, 32'd0, 32'd0, 2'b00, 0, 1, 1);
        check("swap_f", {28'd0, bus.Flags}, 32'b0110);
        check("swap_s", {28'd0, bus.SavedFlags}, 32'b1001);

        apply("rst_upd", 1'b0, 1, 0, 2'd0, 32'h7FFF_FFFF, 32'h1, 2'b11, 1, 1, 0);
        check("rst_upd_f", {28'd0, bus.Flags}, 32'h0);
        check("rst_upd_s", {28'd0, bus.SavedFlags}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom();
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
            if ($urandom_range(0, 4) == 0) ra = {$urandom_range(0, 1) == 1, 31'h7FFF_FFFF};
            apply("rand", $urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), ra, rb,
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end
endmodule
